// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between port A and port B.
// Each grant runs a burst of len+1 consecutive words, one beat per cycle.
module dmem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int LW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [LW-1:0] a_len,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_wbeat,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic          a_done,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [LW-1:0] b_len,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_wbeat,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          b_done,
  output logic [AW-1:0] mem_access_addr,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_write_en,
  output logic          mem_read,
  input  logic [DW-1:0] mem_read_data
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_owner;   // 0 = port A, 1 = port B
  logic          r_prio;    // port favoured on the next contention
  logic          r_we;
  logic [AW-1:0] r_base;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_cnt;
  logic          r_a_rvalid;
  logic          r_b_rvalid;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;
  logic          r_a_done;
  logic          r_b_done;

  logic          w_accept;
  logic          w_pick_b;
  logic          w_last;
  logic          w_rd_beat;

  // ---- state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ---- next state and memory-side decode; all strobes come from state so reset kills them at once
  always_comb begin
    w_state_nxt     = r_state;
    w_accept        = 1'b0;
    w_pick_b        = 1'b0;
    w_last          = 1'b0;
    w_rd_beat       = 1'b0;
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    a_wbeat         = 1'b0;
    b_wbeat         = 1'b0;
    a_gnt           = 1'b0;
    b_gnt           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (a_req || b_req) begin
          w_accept    = 1'b1;
          w_pick_b    = b_req && (!a_req || r_prio);
          w_state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        mem_access_addr = r_base + {{(AW-LW){1'b0}}, r_cnt};
        a_gnt           = (r_cnt == '0) && !r_owner;
        b_gnt           = (r_cnt == '0) &&  r_owner;
        if (r_we) begin
          mem_write_en   = 1'b1;
          mem_write_data = r_owner ? b_wdata : a_wdata;
          a_wbeat        = !r_owner;
          b_wbeat        =  r_owner;
        end else begin
          mem_read  = 1'b1;
          w_rd_beat = 1'b1;
        end
        w_last = (r_cnt == r_len);
        if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- burst context and arbitration priority
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
      r_we    <= 1'b0;
      r_base  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_owner <= w_pick_b;
      r_we    <= w_pick_b ? b_we   : a_we;
      r_base  <= w_pick_b ? b_addr : a_addr;
      r_len   <= w_pick_b ? b_len  : a_len;
      r_cnt   <= '0;
    end else if (r_state == S_BURST) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_prio <= ~r_owner;
    end
  end

  // ---- registered read return and completion pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
      r_a_done   <= 1'b0;
      r_b_done   <= 1'b0;
    end else begin
      r_a_rvalid <= w_rd_beat && !r_owner;
      r_b_rvalid <= w_rd_beat &&  r_owner;
      if (w_rd_beat && !r_owner) r_a_rdata <= mem_read_data;
      if (w_rd_beat &&  r_owner) r_b_rdata <= mem_read_data;
      r_a_done   <= w_last && !r_owner;
      r_b_done   <= w_last &&  r_owner;
    end
  end

  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;
  assign a_done   = r_a_done;
  assign b_done   = r_b_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, b_addr, a_wdata, b_wdata;
  logic [2:0]  a_len, b_len;
  logic        a_gnt, a_wbeat, a_rvalid, a_done;
  logic        b_gnt, b_wbeat, b_rvalid, b_done;
  logic [15:0] a_rdata, b_rdata;
  logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read;

  logic [15:0] mem [0:65535] = '{default: 16'h0000};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_write_en) mem[mem_access_addr] <= mem_write_data;

  assign mem_read_data = mem_read ? mem[mem_access_addr] : 16'h0000;

  dmem_arbiter #(.AW(16), .DW(16), .LW(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_len(a_len), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_wbeat(a_wbeat), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_done(a_done),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_len(b_len), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_wbeat(b_wbeat), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_done(b_done),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_gnt"},    a_gnt,    0);
    chk({tag, "_a_wbeat"},  a_wbeat,  0);
    chk({tag, "_a_rvalid"}, a_rvalid, 0);
    chk({tag, "_a_rdata"},  a_rdata,  0);
    chk({tag, "_a_done"},   a_done,   0);
    chk({tag, "_b_gnt"},    b_gnt,    0);
    chk({tag, "_b_rvalid"}, b_rvalid, 0);
    chk({tag, "_b_rdata"},  b_rdata,  0);
    chk({tag, "_b_done"},   b_done,   0);
    chk({tag, "_addr"},     mem_access_addr, 0);
    chk({tag, "_wdata"},    mem_write_data,  0);
    chk({tag, "_wen"},      mem_write_en,    0);
    chk({tag, "_rd"},       mem_read,        0);
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] wd1 [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] wd4 [3] = '{16'hAAA1, 16'hAAA2, 16'hAAA3};
  logic [15:0] ad4 [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};

  initial begin
    reset_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = 0; a_len = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_len = 0; b_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    reset_n = 1'b1;

    // A write burst addr 0, len 3
    a_req = 1; a_we = 1; a_addr = 16'h0000; a_len = 3;
    #1 chk("t1_idle_gnt", a_gnt, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      a_req = 0; a_wdata = wd1[i];
      #1;
      chk("t1_gnt",   a_gnt, (i == 0));
      chk("t1_wen",   mem_write_en, 1);
      chk("t1_addr",  mem_access_addr, i);
      chk("t1_wdata", mem_write_data, wd1[i]);
      chk("t1_wbeat", a_wbeat, 1);
      chk("t1_done",  a_done, 0);
    end
    cyc(); #1;
    chk("t1_done_end", a_done, 1);
    chk("t1_wen_end",  mem_write_en, 0);

    // A read burst addr 0, len 3
    a_req = 1; a_we = 0; a_addr = 16'h0000; a_len = 3;
    cyc(); a_req = 0; #1;
    chk("t2_gnt", a_gnt, 1);
    chk("t2_rd",  mem_read, 1);
    chk("t2_rv0", a_rvalid, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("t2_rvalid", a_rvalid, 1);
      chk("t2_rdata",  a_rdata, wd1[i]);
      chk("t2_done",   a_done, (i == 3));
    end
    cyc(); #1;
    chk("t2_rv_off",  a_rvalid, 0);
    chk("t2_rd_hold", a_rdata, 16'h4444);

    // reset, then contention from reset: A first, B next, A again
    reset_n = 1'b0;
    #1 chk_zero("rst2");
    cyc(); reset_n = 1'b1;
    a_req = 1; a_we = 0; a_addr = 16'h0000; a_len = 1;
    b_req = 1; b_we = 0; b_addr = 16'h0002; b_len = 0;
    #1 chk("t3_idle_gnt", a_gnt, 0);
    cyc(); a_req = 0; #1;
    chk("t3_a_gnt", a_gnt, 1);
    chk("t3_b_gnt", b_gnt, 0);
    cyc(); #1;
    chk("t3_a_rd0", a_rdata, 16'h1111);
    chk("t3_b_gnt2", b_gnt, 0);
    cyc(); #1;
    chk("t3_a_done", a_done, 1);
    chk("t3_a_rd1",  a_rdata, 16'h2222);
    chk("t3_b_gnt3", b_gnt, 0);
    cyc(); b_req = 0; a_req = 1; a_addr = 16'h0003; a_len = 0; #1;
    chk("t3_b_gnt4", b_gnt, 1);
    chk("t3_b_addr", mem_access_addr, 16'h0002);
    cyc(); b_req = 1; #1;
    chk("t3_b_done",  b_done, 1);
    chk("t3_b_rv",    b_rvalid, 1);
    chk("t3_b_rdata", b_rdata, 16'h3333);
    chk("t3_a_wait",  a_gnt, 0);
    cyc(); a_req = 0; b_req = 0; #1;
    chk("t3_alt_a", a_gnt, 1);
    chk("t3_alt_b", b_gnt, 0);
    cyc(); #1;
    chk("t3_a2_done",  a_done, 1);
    chk("t3_a2_rdata", a_rdata, 16'h4444);

    // B write across the address wrap
    b_req = 1; b_we = 1; b_addr = 16'hFFFE; b_len = 2;
    for (int i = 0; i < 3; i++) begin
      cyc(); b_req = 0; b_wdata = wd4[i]; #1;
      chk("t4_gnt",   b_gnt, (i == 0));
      chk("t4_addr",  mem_access_addr, ad4[i]);
      chk("t4_wdata", mem_write_data, wd4[i]);
      chk("t4_wbeat", b_wbeat, 1);
      chk("t4_awbt",  a_wbeat, 0);
    end
    cyc(); #1;
    chk("t4_done", b_done, 1);
    chk("t4_wen",  mem_write_en, 0);

    // B single-word read while A waits
    b_req = 1; b_we = 0; b_addr = 16'hFFFF; b_len = 0;
    cyc(); b_req = 0; a_req = 1; a_we = 0; a_addr = 16'h0000; a_len = 0; #1;
    chk("t5_b_gnt", b_gnt, 1);
    chk("t5_addr",  mem_access_addr, 16'hFFFF);
    chk("t5_a_gnt", a_gnt, 0);
    cyc(); #1;
    chk("t5_b_done",  b_done, 1);
    chk("t5_b_rdata", b_rdata, 16'hAAA2);
    chk("t5_a_wait",  a_gnt, 0);
    cyc(); a_req = 0; #1;
    chk("t5_a_gnt2", a_gnt, 1);
    chk("t5_b_rvoff", b_rvalid, 0);
    cyc(); #1;
    chk("t5_a_rdata", a_rdata, 16'hAAA3);
    chk("t5_a_done",  a_done, 1);

    // reset during the third beat of a 4-beat write
    a_req = 1; a_we = 1; a_addr = 16'h0010; a_len = 3;
    cyc(); a_req = 0; a_wdata = 16'h0005; #1;
    chk("t6_addr0", mem_access_addr, 16'h0010);
    cyc(); a_wdata = 16'h0006; #1;
    chk("t6_addr1", mem_access_addr, 16'h0011);
    cyc(); a_wdata = 16'h0007; #1;
    chk("t6_wen2", mem_write_en, 1);
    reset_n = 1'b0;
    #1 chk_zero("t6_rst");
    cyc();
    chk("t6_m10", mem[16'h0010], 16'h0005);
    chk("t6_m11", mem[16'h0011], 16'h0006);
    chk("t6_m12", mem[16'h0012], 16'h0000);
    reset_n = 1'b1;
    a_req = 1; a_we = 0; a_addr = 16'h0010; a_len = 2;
    b_req = 1; b_we = 0; b_addr = 16'h0000; b_len = 0;
    #1;
    cyc(); a_req = 0; #1;
    chk("t6_a_gnt", a_gnt, 1);
    chk("t6_b_gnt", b_gnt, 0);
    cyc(); #1 chk("t6_rd0", a_rdata, 16'h0005);
    cyc(); #1 chk("t6_rd1", a_rdata, 16'h0006);
    cyc(); #1;
    chk("t6_rd2",  a_rdata, 16'h0000);
    chk("t6_done", a_done, 1);
    cyc(); b_req = 0; #1 chk("t6_b_gnt2", b_gnt, 1);
    cyc(); #1;
    chk("t6_b_rv",    b_rvalid, 1);
    chk("t6_b_rdata", b_rdata, 16'hAAA3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
